argument_pop_arbiter: RTL and testbench
=======================================

# argument_pop_arbiter

Shares one `argument_decoder` output stream among `NUM_REQ` field-consumers. Each consumer requests a bit-field of a given length. The arbiter grants one requester per cycle, round-robin, with optional lock for multi-field sequences. It drives the decoder's `pop` and returns the LSB-aligned, masked field with the winner's ID through a one-entry registered response stage with backpressure. It sits between the decoder's `q`/`ready`/`pop` and the argument-parsing consumers.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `WIDTH_OUT`, 64: decoder output width.
- `LOG2_WIDTH_OUT`, `log2(WIDTH_OUT)`: width of `pop` and of each length field.
- `LOG2_NUM_REQ`, `log2(NUM_REQ)`: ID width.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-low reset.
- `req`, in, `NUM_REQ`: per-requester request, held until granted.
- `req_len`, in, `NUM_REQ*LOG2_WIDTH_OUT`: field length for requester i, in slice i. Legal range 1..`WIDTH_OUT-1`.
- `req_lock`, in, `NUM_REQ`: the requester keeps priority after its grant while this bit is high.
- `grant`, out, `NUM_REQ`: one-hot, combinational, same cycle as the pop.
- `dec_ready`, in, 1: decoder `ready`.
- `dec_q`, in, `WIDTH_OUT`: decoder `q`. The next unconsumed bit is at bit 0.
- `dec_pop`, out, `LOG2_WIDTH_OUT`: bits to consume; 0 means no pop.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_id`, out, `LOG2_NUM_REQ`: index of the requester that owns the response.
- `rsp_data`, out, `WIDTH_OUT`: `dec_q` with bits at and above `len` forced to 0.
- `underflow`, out, 1: sticky error flag.

## Operation
**Eligibility**
- Requester i is eligible when `req[i]` is high and `len_i != 0`.
- A request with length 0 is never granted and never sets an error.

**Grant condition.** A grant occurs in a cycle when all of these hold:
- `dec_ready` is high;
- at least one requester is eligible;
- the response stage is free or draining: `!rsp_valid || rsp_ready`.

**Arbitration states**
- ROUND_ROBIN:
  - The winner is the first eligible index at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - On a grant, `rr_ptr` becomes winner+1 (wrapping).
  - If the winner's `req_lock` is high, go to LOCKED with owner = winner.
- LOCKED:
  - The owner wins whenever it is eligible. Other requesters are not considered.
  - When the owner's `req_lock` drops (sampled each cycle), return to ROUND_ROBIN. `rr_ptr` is unchanged, i.e. owner+1.
  - If the owner's `req` is low while `req_lock` is high, no grant is issued. There is no timeout.

**Pop and response**
- On a grant: `dec_pop = len_winner`.
- The response register loads {id, masked `dec_q`} at the clock edge and `rsp_valid` is set.
- `rsp_valid` clears when `rsp_ready` is high and no new grant occurs in that cycle.
- Without a grant, `dec_pop = 0` and `grant = 0`.

**Underflow.** `underflow` is set when any eligible `req` is present while `dec_ready` is low for more than 1024 consecutive cycles. It is cleared only by reset.

## Timing
**Reset values:**
- `grant=0`, `dec_pop=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `underflow=0`;
- state = ROUND_ROBIN, `rr_ptr=0`, stall counter = 0.

**Latency and throughput**
- Grant to `rsp_valid` is 1 cycle.
- Sustained throughput is 1 grant per cycle while `dec_ready` and `rsp_ready` stay high.

**Combinational paths**
- `grant` and `dec_pop` depend combinationally on `req`, `req_len`, `dec_ready` and `rsp_ready`.
- The decoder consumes at the same edge that the response register loads.

**Boundary conditions**
- **Simultaneous accept and new grant:** the response register reloads and `rsp_valid` stays high.
- **Full stage:** `rsp_valid && !rsp_ready` blocks grants, so `dec_pop = 0`.
- **Reset mid-operation:** reset low at an edge overrides every other update. A pop presented in that cycle is still seen by the decoder. The decoder shares the same reset.
- **Wrap-around:** the `rr_ptr` update modulo `NUM_REQ` uses width `LOG2_NUM_REQ`. For non-power-of-2 `NUM_REQ`, the value `NUM_REQ-1` wraps to 0.

## Structure
- Shared header `common.vh`: provides the `log2` function, the state encodings (`ARB_RR=0`, `ARB_LOCKED=1`) and the 1024-cycle stall limit constant `ARB_STALL_LIMIT`.
- Sub-module `rr_priority_select`:
  - Combinational.
  - Inputs: eligible vector, `rr_ptr`.
  - Outputs: one-hot winner, winner index, any-valid.
- The top level holds the state machine, `rr_ptr`, the response register, the masking logic and the stall counter.

## Test plan
- **Single requester:** reset, then `req[2]=1`, `len=5`, `dec_ready=1`, `dec_q=0x...FF`. Required: `grant=4'b0100` and `dec_pop=5` in the same cycle. Next cycle: `rsp_valid=1`, `rsp_id=2`, `rsp_data=0x1F`.
- **Round-robin:** all four `req` high with lengths 1,2,3,4. Required: grants in the order 0,1,2,3,0 on consecutive cycles, with `dec_pop` 1,2,3,4,1.
- **Lock:** `req[1]` and `req[3]` high, `req_lock[1]` high for 3 grants. Required: grants 1,1,1, then 3 after the lock drops, then 1.
- **Backpressure:** hold `rsp_ready=0` after the first grant. Required: `dec_pop=0`, `grant=0`, and `rsp_data` held. Raising `rsp_ready` resumes grants the same cycle.
- **Ready low and zero length:** with `dec_ready=0` there are no grants; after 1025 cycles `underflow=1`. With `len=0` and `req` high there is never a grant.
- **Mid-burst reset:** pull `rst` low during a locked burst. The next cycle shows the reset values, `rr_ptr=0`, and the first grant after release goes to index 0.

Source files
------------

// File: rtl/argument_pop_arbiter_pkg.sv
// argument_pop_arbiter_pkg
// Shared definitions for the argument pop arbiter: arbitration state
// encoding, the decoder stall limit and a constant-evaluable log2 helper
// used to size ports and counters.
package argument_pop_arbiter_pkg;

    typedef enum logic {
        ARB_RR     = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Consecutive starved cycles tolerated before underflow is flagged.
    localparam int unsigned ARB_STALL_LIMIT = 1024;

    // Ceiling log2, never less than 1 so derived widths stay legal.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/argument_pop_arbiter_rr_priority_select.sv
// rr_priority_select
// Combinational round-robin picker: returns the first eligible index at or
// after rr_ptr, wrapping modulo NUM_REQ.
// Ports:
//   eligible      - per-requester eligibility vector
//   rr_ptr        - index holding the highest priority this cycle
//   winner_onehot - one-hot winner (all zero when nothing eligible)
//   winner_idx    - binary winner index (0 when nothing eligible)
//   any_valid     - at least one requester eligible
module rr_priority_select #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOG2_NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]      eligible,
    input  logic [LOG2_NUM_REQ-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]      winner_onehot,
    output logic [LOG2_NUM_REQ-1:0] winner_idx,
    output logic                    any_valid
);

    // Two ordered passes: first indices at or above the pointer, then the
    // wrapped-around remainder from index 0.
    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        any_valid     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && eligible[i] && (i >= 32'(rr_ptr))) begin
                any_valid        = 1'b1;
                winner_onehot[i] = 1'b1;
                winner_idx       = LOG2_NUM_REQ'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && eligible[i]) begin
                any_valid        = 1'b1;
                winner_onehot[i] = 1'b1;
                winner_idx       = LOG2_NUM_REQ'(i);
            end
        end
    end

endmodule

// File: rtl/argument_pop_arbiter.sv
// argument_pop_arbiter
// Shares one argument_decoder output stream among NUM_REQ field consumers.
// One grant per cycle, round-robin with optional lock; drives the decoder
// pop and returns the LSB-aligned masked field through a one-entry
// registered response stage with backpressure.
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   req/req_len/req_lock - per-requester request, field length, lock
//   grant             - one-hot combinational grant
//   dec_ready/dec_q   - decoder status and data (next bit at bit 0)
//   dec_pop           - bits consumed this cycle (0 = none)
//   rsp_valid/rsp_ready/rsp_id/rsp_data - registered response
//   underflow         - sticky decoder starvation flag
module argument_pop_arbiter
    import argument_pop_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned WIDTH_OUT      = 64,
    parameter int unsigned LOG2_WIDTH_OUT = log2(WIDTH_OUT),
    parameter int unsigned LOG2_NUM_REQ   = log2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*LOG2_WIDTH_OUT-1:0] req_len,
    input  logic [NUM_REQ-1:0]                req_lock,
    output logic [NUM_REQ-1:0]                grant,
    input  logic                              dec_ready,
    input  logic [WIDTH_OUT-1:0]              dec_q,
    output logic [LOG2_WIDTH_OUT-1:0]         dec_pop,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [LOG2_NUM_REQ-1:0]           rsp_id,
    output logic [WIDTH_OUT-1:0]              rsp_data,
    output logic                              underflow
);

    localparam int unsigned STALL_W = log2(ARB_STALL_LIMIT + 1);

    arb_state_e                state_q, state_d;
    logic [LOG2_NUM_REQ-1:0]   owner_q, owner_d;
    logic [LOG2_NUM_REQ-1:0]   rr_ptr_q, rr_ptr_d;
    logic [STALL_W-1:0]        stall_cnt;

    logic [LOG2_WIDTH_OUT-1:0] lens [NUM_REQ];
    logic [NUM_REQ-1:0]        eligible;
    logic [NUM_REQ-1:0]        arb_elig;
    logic [NUM_REQ-1:0]        owner_mask;
    logic [NUM_REQ-1:0]        win_onehot;
    logic [LOG2_NUM_REQ-1:0]   win_idx;
    logic [LOG2_WIDTH_OUT-1:0] win_len;
    logic                      win_any;
    logic                      locked_active;
    logic                      fire;
    logic [WIDTH_OUT-1:0]      field_mask;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            lens[i]     = req_len[i*LOG2_WIDTH_OUT +: LOG2_WIDTH_OUT];
            eligible[i] = req[i] && (lens[i] != '0);
        end
    end

    // Lock only holds while the owner keeps req_lock high; the cycle it
    // drops, arbitration falls back to round-robin from owner+1.
    assign locked_active = (state_q == ARB_LOCKED) && req_lock[owner_q];
    assign owner_mask    = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign arb_elig      = locked_active ? (eligible & owner_mask) : eligible;

    rr_priority_select #(
        .NUM_REQ      (NUM_REQ),
        .LOG2_NUM_REQ (LOG2_NUM_REQ)
    ) u_select (
        .eligible      (arb_elig),
        .rr_ptr        (rr_ptr_q),
        .winner_onehot (win_onehot),
        .winner_idx    (win_idx),
        .any_valid     (win_any)
    );

    always_comb begin
        win_len = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_len = lens[i];
            end
        end
    end

    assign fire       = dec_ready && win_any && (!rsp_valid || rsp_ready);
    assign grant      = fire ? win_onehot : '0;
    assign dec_pop    = fire ? win_len : '0;
    assign field_mask = ~({WIDTH_OUT{1'b1}} << win_len);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if ((state_q == ARB_LOCKED) && !req_lock[owner_q]) begin
            state_d = ARB_RR;
        end
        if (fire) begin
            rr_ptr_d = (win_idx == LOG2_NUM_REQ'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (req_lock[win_idx]) begin
                state_d = ARB_LOCKED;
                owner_d = win_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ARB_RR;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (fire) begin
            rsp_valid <= 1'b1;
            rsp_id    <= win_idx;
            rsp_data  <= dec_q & field_mask;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            underflow <= 1'b0;
        end else if ((|eligible) && !dec_ready) begin
            if (stall_cnt == STALL_W'(ARB_STALL_LIMIT)) begin
                underflow <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_argument_pop_arbiter.sv
module tb_argument_pop_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [23:0] req_len;
    logic [3:0]  req_lock;
    logic [3:0]  grant;
    logic        dec_ready;
    logic [63:0] dec_q;
    logic [5:0]  dec_pop;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [63:0] rsp_data;
    logic        underflow;

    argument_pop_arbiter #(
        .NUM_REQ   (4),
        .WIDTH_OUT (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .req_lock  (req_lock),
        .grant     (grant),
        .dec_ready (dec_ready),
        .dec_q     (dec_q),
        .dec_pop   (dec_pop),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        logic [3:0]  req;
        logic [23:0] len;
        logic [3:0]  lock;
        logic        rdy;
        logic        rrdy;
        logic [3:0]  exp_grant;
        logic [5:0]  exp_pop;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] data;
    } rsp_t;

    localparam int NV = 23;
    vec_t vt [NV];
    rsp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [23:0] L(input logic [5:0] a, input logic [5:0] b,
                                      input logic [5:0] c, input logic [5:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [1:0] oh_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    function automatic logic [63:0] model_mask(input logic [63:0] q, input int len);
        logic [63:0] d;
        d = 64'd0;
        for (int b = 0; b < 64; b++) if (b < len) d[b] = q[b];
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        req = 4'd0; req_lock = 4'd0; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_pop", 64'(dec_pop), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        sb.delete();
    endtask

    // Drive one vector, check combinational grant/pop and the held response
    // against the scoreboard, then advance one clock.
    task automatic apply(input vec_t v, input int n);
        rsp_t e;
        int   wl;
        if (v.do_rst) do_reset();
        req = v.req; req_len = v.len; req_lock = v.lock;
        dec_ready = v.rdy; rsp_ready = v.rrdy;
        dec_q = {$urandom, $urandom};
        #1;
        chk($sformatf("v%0d_grant", n), 64'(grant), 64'(v.exp_grant));
        chk($sformatf("v%0d_pop", n), 64'(dec_pop), 64'(v.exp_pop));
        chk($sformatf("v%0d_rsp_valid", n), 64'(rsp_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk($sformatf("v%0d_rsp_id", n), 64'(rsp_id), 64'(sb[0].id));
            chk($sformatf("v%0d_rsp_data", n), rsp_data, sb[0].data);
            if (v.rrdy) void'(sb.pop_front());
        end
        if (v.exp_grant != 4'd0) begin
            e.id = oh_idx(v.exp_grant);
            wl = int'(v.len[6*e.id +: 6]);
            e.data = model_mask(dec_q, wl);
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; req = 4'd0; req_len = 24'd0; req_lock = 4'd0;
        dec_ready = 1'b0; dec_q = 64'd0; rsp_ready = 1'b1;

        // do_rst, req, len, lock, dec_ready, rsp_ready, exp_grant, exp_pop
        vt[0]  = '{1'b1, 4'b0100, L(0,0,5,0), 4'b0000, 1'b1, 1'b1, 4'b0100, 6'd5};
        vt[1]  = '{1'b0, 4'b0000, L(0,0,5,0), 4'b0000, 1'b1, 1'b1, 4'b0000, 6'd0};
        vt[2]  = '{1'b1, 4'b1111, L(1,2,3,4), 4'b0000, 1'b1, 1'b1, 4'b0001, 6'd1};
        vt[3]  = '{1'b0, 4'b1111, L(1,2,3,4), 4'b0000, 1'b1, 1'b1, 4'b0010, 6'd2};
        vt[4]  = '{1'b0, 4'b1111, L(1,2,3,4), 4'b0000, 1'b1, 1'b1, 4'b0100, 6'd3};
        vt[5]  = '{1'b0, 4'b1111, L(1,2,3,4), 4'b0000, 1'b1, 1'b1, 4'b1000, 6'd4};
        vt[6]  = '{1'b0, 4'b1111, L(1,2,3,4), 4'b0000, 1'b1, 1'b1, 4'b0001, 6'd1};
        vt[7]  = '{1'b0, 4'b0000, L(1,2,3,4), 4'b0000, 1'b1, 1'b1, 4'b0000, 6'd0};
        vt[8]  = '{1'b1, 4'b1010, L(0,3,0,6), 4'b0010, 1'b1, 1'b1, 4'b0010, 6'd3};
        vt[9]  = '{1'b0, 4'b1010, L(0,3,0,6), 4'b0010, 1'b1, 1'b1, 4'b0010, 6'd3};
        vt[10] = '{1'b0, 4'b1010, L(0,3,0,6), 4'b0010, 1'b1, 1'b1, 4'b0010, 6'd3};
        vt[11] = '{1'b0, 4'b1010, L(0,3,0,6), 4'b0000, 1'b1, 1'b1, 4'b1000, 6'd6};
        vt[12] = '{1'b0, 4'b1010, L(0,3,0,6), 4'b0000, 1'b1, 1'b1, 4'b0010, 6'd3};
        vt[13] = '{1'b0, 4'b0000, L(0,3,0,6), 4'b0000, 1'b1, 1'b1, 4'b0000, 6'd0};
        vt[14] = '{1'b0, 4'b0001, L(0,2,0,0), 4'b0000, 1'b1, 1'b1, 4'b0000, 6'd0};
        vt[15] = '{1'b0, 4'b0011, L(0,2,0,0), 4'b0000, 1'b1, 1'b1, 4'b0010, 6'd2};
        vt[16] = '{1'b0, 4'b0001, L(0,2,0,0), 4'b0000, 1'b1, 1'b1, 4'b0000, 6'd0};
        vt[17] = '{1'b1, 4'b0001, L(4,0,0,0), 4'b0000, 1'b1, 1'b1, 4'b0001, 6'd4};
        vt[18] = '{1'b0, 4'b0001, L(4,0,0,0), 4'b0000, 1'b1, 1'b0, 4'b0000, 6'd0};
        vt[19] = '{1'b0, 4'b0001, L(4,0,0,0), 4'b0000, 1'b1, 1'b0, 4'b0000, 6'd0};
        vt[20] = '{1'b0, 4'b0001, L(4,0,0,0), 4'b0000, 1'b1, 1'b1, 4'b0001, 6'd4};
        vt[21] = '{1'b0, 4'b0001, L(4,0,0,0), 4'b0000, 1'b0, 1'b1, 4'b0000, 6'd0};
        vt[22] = '{1'b0, 4'b0000, L(4,0,0,0), 4'b0000, 1'b1, 1'b1, 4'b0000, 6'd0};

        @(posedge clk); #1;
        for (int n = 0; n < NV; n++) apply(vt[n], n);

        // Mid-burst reset: locked on requester 1, reset must clear lock and rr_ptr.
        do_reset();
        req = 4'b1010; req_len = L(0,3,0,6); req_lock = 4'b0010;
        dec_ready = 1'b1; rsp_ready = 1'b1; dec_q = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            #1 chk("burst_grant", 64'(grant), 64'b0010);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1 chk("reset_cycle_pop", 64'(dec_pop), 64'd3);
        @(posedge clk); #1;
        rst = 1'b1; req = 4'd0; req_lock = 4'd0;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("mid_rst_rsp_data", rsp_data, 64'd0);
        chk("mid_rst_grant", 64'(grant), 64'd0);
        req = 4'b1111; req_len = L(1,2,3,4);
        #1 chk("post_rst_first_grant", 64'(grant), 64'b0001);
        @(posedge clk); #1;
        req = 4'd0;

        // Decoder starvation: underflow after more than 1024 stalled cycles.
        do_reset();
        req = 4'b0001; req_len = L(3,0,0,0); dec_ready = 1'b0;
        #1 chk("stall_grant", 64'(grant), 64'd0);
        chk("stall_pop", 64'(dec_pop), 64'd0);
        repeat (1024) @(posedge clk);
        #1 chk("underflow_at_1024", 64'(underflow), 64'd0);
        @(posedge clk); #1;
        chk("underflow_at_1025", 64'(underflow), 64'd1);
        req = 4'd0; dec_ready = 1'b1;
        @(posedge clk); #1;
        chk("underflow_sticky", 64'(underflow), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
